// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: one-at-a-time ALU command sequencer. Logic, add/sub, shift and
// illegal opcodes finish in one cycle; MUL (shift-add) and DIV (restoring)
// iterate once per operand bit on a shared work register pair.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_a, cmd_b, cmd_cin command opcode, operands, carry/borrow-in
//   rsp_valid/rsp_ready           response handshake
//   rsp_hi, rsp_lo                double-width result
//   rsp_carry, rsp_err            ADD carry / SUB borrow, illegal-op flag
//
// Build option: define ALU_SEQ_DIVZERO_TRAP_EN to turn DIV by zero into a
// single-cycle error response instead of iterating.

module alu_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_hi,
    output logic [WIDTH-1:0] rsp_lo,
    output logic             rsp_carry,
    output logic             rsp_err
);

    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_NAND  = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_NOR   = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_XNOR  = 4'd5;
    localparam logic [3:0] OP_NOT   = 4'd6;
    localparam logic [3:0] OP_ADD   = 4'd7;
    localparam logic [3:0] OP_SUB   = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;
    localparam logic [3:0] OP_DIV   = 4'd10;
    localparam logic [3:0] OP_SHIFT = 4'd11;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [2*WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t state;
    state_t state_next;

    logic             accept;
    logic             div_zero;
    logic             is_iter;

    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             carry_q;
    logic             err_q;

    // single-cycle result path, computed straight from the command inputs
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;
    logic               res_carry;
    logic               res_err;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_dif;
    logic [WIDTH-3:0]   sh_amt;
    logic [2*WIDTH-1:0] sh_left;
    logic [2*WIDTH-1:0] sh_right;

    // iteration path
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_dif;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    assign accept = cmd_valid && cmd_ready;

`ifdef ALU_SEQ_DIVZERO_TRAP_EN
    assign div_zero = (cmd_op == OP_DIV) && (cmd_b == '0);
`else
    assign div_zero = 1'b0;
`endif

    assign is_iter = (cmd_op == OP_MUL) ||
                     ((cmd_op == OP_DIV) && !div_zero);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = is_iter ? EXEC : DONE;
                end
            end
            EXEC: begin
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (rsp_valid && rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // reset_n gates the outputs so they read zero for the whole reset cycle
    always_comb begin
        cmd_ready = (state == IDLE) && reset_n;
        rsp_valid = (state == DONE) && reset_n;
        rsp_hi    = reset_n ? hi_q : '0;
        rsp_lo    = reset_n ? lo_q : '0;
        rsp_carry = reset_n && carry_q;
        rsp_err   = reset_n && err_q;
    end

    // ---------------- single-cycle datapath ----------------
    always_comb begin
        res_hi    = '0;
        res_lo    = '0;
        res_carry = 1'b0;
        res_err   = 1'b0;
        add_sum   = {1'b0, cmd_a} + {1'b0, cmd_b}
                  + {{WIDTH{1'b0}}, cmd_cin};
        sub_dif   = {1'b0, cmd_a} - {1'b0, cmd_b}
                  - {{WIDTH{1'b0}}, cmd_cin};
        sh_amt    = cmd_b[WIDTH-2:1];
        sh_left   = {{WIDTH{1'b0}}, cmd_a} << sh_amt;
        sh_right  = {cmd_a, {WIDTH{1'b0}}} >> sh_amt;
        // vacated positions take the fill bit
        if (cmd_b[0]) begin
            sh_left  = sh_left | ~(ONES << sh_amt);
            sh_right = sh_right | ~(ONES >> sh_amt);
        end
        case (cmd_op)
            OP_AND:  res_lo = cmd_a & cmd_b;
            OP_NAND: res_lo = ~(cmd_a & cmd_b);
            OP_OR:   res_lo = cmd_a | cmd_b;
            OP_NOR:  res_lo = ~(cmd_a | cmd_b);
            OP_XOR:  res_lo = cmd_a ^ cmd_b;
            OP_XNOR: res_lo = ~(cmd_a ^ cmd_b);
            OP_NOT:  res_lo = ~cmd_a;
            OP_ADD: begin
                res_lo    = add_sum[WIDTH-1:0];
                res_carry = add_sum[WIDTH];
            end
            OP_SUB: begin
                res_lo    = sub_dif[WIDTH-1:0];
                res_carry = sub_dif[WIDTH];
            end
            OP_MUL: res_err = 1'b0;
            OP_DIV: res_err = div_zero;
            OP_SHIFT: begin
                if (cmd_b[WIDTH-1]) begin
                    res_lo = sh_left[WIDTH-1:0];
                    res_hi = sh_left[2*WIDTH-1:WIDTH];
                end else begin
                    res_lo = sh_right[2*WIDTH-1:WIDTH];
                    res_hi = sh_right[WIDTH-1:0];
                end
            end
            default: res_err = 1'b1;
        endcase
    end

    // ---------------- iterative datapath ----------------
    // MUL: work_hi is the partial product, work_lo the multiplier being
    // shifted out LSB first while product bits shift in from the top.
    // DIV: work_hi is the remainder, work_lo the dividend shifting out MSB
    // first while quotient bits shift in at the bottom.
    always_comb begin
        mul_sum = {1'b0, work_hi}
                + (work_lo[0] ? {1'b0, a_q} : '0);
        rem_sh  = {work_hi, work_lo[WIDTH-1]};
        rem_ge  = rem_sh >= {1'b0, b_q};
        rem_dif = rem_sh[WIDTH-1:0] - b_q;
        if (op_q == OP_MUL) begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else begin
            iter_hi = rem_ge ? rem_dif : rem_sh[WIDTH-1:0];
            iter_lo = {work_lo[WIDTH-2:0], rem_ge};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt     <= '0;
            work_hi <= '0;
            work_lo <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                op_q    <= cmd_op;
                a_q     <= cmd_a;
                b_q     <= cmd_b;
                cnt     <= '0;
                work_hi <= '0;
                work_lo <= (cmd_op == OP_MUL) ? cmd_b : cmd_a;
                // iterative ops see all-zero here, clearing stale results
                hi_q    <= res_hi;
                lo_q    <= res_lo;
                carry_q <= res_carry;
                err_q   <= res_err;
            end
        end else if (state == EXEC) begin
            work_hi <= iter_hi;
            work_lo <= iter_lo;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST) begin
                hi_q    <= iter_hi;
                lo_q    <= iter_lo;
                carry_q <= 1'b0;
                err_q   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: vector table plus scoreboard bench for alu_seq_ctrl at
// WIDTH = 4, with hand sequences for response stall and mid-MUL reset.

`timescale 1ns/1ps

module tb_alu_seq_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [3:0]   cmd_op = '0;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic         cmd_cin = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_hi;
    logic [W-1:0] rsp_lo;
    logic         rsp_carry;
    logic         rsp_err;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] hi;
        logic [3:0] lo;
        logic       carry;
        logic       err;
        logic [7:0] lat;
    } vec_t;

    localparam int NT = 25;
    vec_t tbl [0:NT-1];
    vec_t sb [$];

    alu_seq_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_cin   (cmd_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_hi    (rsp_hi),
        .rsp_lo    (rsp_lo),
        .rsp_carry (rsp_carry),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic [3:0] a,
                                input logic [3:0] b, input logic cin,
                                input logic [3:0] hi, input logic [3:0] lo,
                                input logic carry, input logic err,
                                input logic [7:0] lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.cin = cin;
        v.hi = hi; v.lo = lo; v.carry = carry; v.err = err; v.lat = lat;
        return v;
    endfunction

    // reference model written from the arithmetic definitions
    function automatic vec_t model(input logic [3:0] op, input logic [3:0] a,
                                   input logic [3:0] b, input logic cin);
        vec_t v;
        logic [7:0] r;
        logic [4:0] s;
        int amt;
        v = mk(op, a, b, cin, 4'h0, 4'h0, 1'b0, 1'b0, 8'd1);
        r = '0;
        case (op)
            4'd0: v.lo = a & b;
            4'd1: v.lo = ~(a & b);
            4'd2: v.lo = a | b;
            4'd3: v.lo = ~(a | b);
            4'd4: v.lo = a ^ b;
            4'd5: v.lo = ~(a ^ b);
            4'd6: v.lo = ~a;
            4'd7: begin
                s = 5'(a) + 5'(b) + 5'(cin);
                v.lo = s[3:0];
                v.carry = s[4];
            end
            4'd8: begin
                v.lo = 4'(int'(a) - int'(b) - int'(cin));
                v.carry = (int'(a) < int'(b) + int'(cin));
            end
            4'd9: begin
                r = 8'(int'(a) * int'(b));
                v.hi = r[7:4];
                v.lo = r[3:0];
                v.lat = 8'd5;
            end
            4'd10: begin
                if (b == 4'h0) begin
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
                    v.err = 1'b1;
`else
                    v.lo = 4'hF;
                    v.hi = a;
                    v.lat = 8'd5;
`endif
                end else begin
                    v.lo = 4'(int'(a) / int'(b));
                    v.hi = 4'(int'(a) % int'(b));
                    v.lat = 8'd5;
                end
            end
            4'd11: begin
                amt = int'(b[2:1]);
                for (int i = 0; i < 8; i++) begin
                    if (b[3]) begin
                        if (i < amt) r[i] = b[0];
                        else if (i - amt < 4) r[i] = a[i-amt];
                        else r[i] = 1'b0;
                    end else begin
                        if (i + amt > 7) r[i] = b[0];
                        else if (i + amt >= 4) r[i] = a[i+amt-4];
                        else r[i] = 1'b0;
                    end
                end
                v.lo = b[3] ? r[3:0] : r[7:4];
                v.hi = b[3] ? r[7:4] : r[3:0];
            end
            default: v.err = 1'b1;
        endcase
        return v;
    endfunction

    // issue one command, then collect and score its response; hold keeps
    // rsp_ready low for that many extra cycles once the response is up
    task automatic run(input vec_t v, input int hold);
        vec_t e;
        int k;
        int lat;
        logic rdy_low;
        string t;
        t = $sformatf("op%0d a=%h b=%h", v.op, v.a, v.b);
        k = 0;
        while (!cmd_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({t, " cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_op = v.op;
        cmd_a = v.a;
        cmd_b = v.b;
        cmd_cin = v.cin;
        cmd_valid = 1'b1;
        sb.push_back(v);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_op = $urandom_range(0, 15);
        cmd_a = $urandom_range(0, 15);
        cmd_b = $urandom_range(0, 15);
        @(negedge clk);
        lat = 1;
        rdy_low = 1'b1;
        while (!rsp_valid && lat < 40) begin
            if (cmd_ready) rdy_low = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (cmd_ready) rdy_low = 1'b0;
        e = sb.pop_front();
        check({t, " busy_ready_low"}, 32'(rdy_low), 32'd1);
        check({t, " latency"}, 32'(lat), 32'(e.lat));
        check({t, " hi"}, 32'(rsp_hi), 32'(e.hi));
        check({t, " lo"}, 32'(rsp_lo), 32'(e.lo));
        check({t, " carry"}, 32'(rsp_carry), 32'(e.carry));
        check({t, " err"}, 32'(rsp_err), 32'(e.err));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({t, " stall_valid"}, 32'(rsp_valid), 32'd1);
            check({t, " stall_ready"}, 32'(cmd_ready), 32'd0);
            check({t, " stall_hi"}, 32'(rsp_hi), 32'(e.hi));
            check({t, " stall_lo"}, 32'(rsp_lo), 32'(e.lo));
            check({t, " stall_err"}, 32'(rsp_err), 32'(e.err));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
        check({t, " ready_after"}, 32'(cmd_ready), 32'd1);
        check({t, " valid_after"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin : main
        logic seen;
        vec_t v;

        tbl[0]  = mk(4'd0,  4'hC, 4'hA, 1'b0, 4'h0, 4'h8, 1'b0, 1'b0, 8'd1);
        tbl[1]  = mk(4'd1,  4'hC, 4'hA, 1'b1, 4'h0, 4'h7, 1'b0, 1'b0, 8'd1);
        tbl[2]  = mk(4'd2,  4'hC, 4'hA, 1'b0, 4'h0, 4'hE, 1'b0, 1'b0, 8'd1);
        tbl[3]  = mk(4'd3,  4'hC, 4'hA, 1'b0, 4'h0, 4'h1, 1'b0, 1'b0, 8'd1);
        tbl[4]  = mk(4'd4,  4'hC, 4'hA, 1'b0, 4'h0, 4'h6, 1'b0, 1'b0, 8'd1);
        tbl[5]  = mk(4'd5,  4'hC, 4'hA, 1'b0, 4'h0, 4'h9, 1'b0, 1'b0, 8'd1);
        tbl[6]  = mk(4'd6,  4'h5, 4'hF, 1'b0, 4'h0, 4'hA, 1'b0, 1'b0, 8'd1);
        tbl[7]  = mk(4'd7,  4'hF, 4'h1, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 8'd1);
        tbl[8]  = mk(4'd7,  4'h5, 4'h9, 1'b1, 4'h0, 4'hF, 1'b0, 1'b0, 8'd1);
        tbl[9]  = mk(4'd8,  4'h3, 4'h5, 1'b0, 4'h0, 4'hE, 1'b1, 1'b0, 8'd1);
        tbl[10] = mk(4'd8,  4'h8, 4'h3, 1'b1, 4'h0, 4'h4, 1'b0, 1'b0, 8'd1);
        tbl[11] = mk(4'd8,  4'h4, 4'h4, 1'b1, 4'h0, 4'hF, 1'b1, 1'b0, 8'd1);
        tbl[12] = mk(4'd9,  4'hD, 4'hB, 1'b0, 4'h8, 4'hF, 1'b0, 1'b0, 8'd5);
        tbl[13] = mk(4'd9,  4'hF, 4'hF, 1'b0, 4'hE, 4'h1, 1'b0, 1'b0, 8'd5);
        tbl[14] = mk(4'd10, 4'hD, 4'h4, 1'b0, 4'h1, 4'h3, 1'b0, 1'b0, 8'd5);
        tbl[15] = mk(4'd10, 4'h7, 4'h9, 1'b0, 4'h7, 4'h0, 1'b0, 1'b0, 8'd5);
`ifdef ALU_SEQ_DIVZERO_TRAP_EN
        tbl[16] = mk(4'd10, 4'h9, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 8'd1);
`else
        tbl[16] = mk(4'd10, 4'h9, 4'h0, 1'b0, 4'h9, 4'hF, 1'b0, 1'b0, 8'd5);
`endif
        tbl[17] = mk(4'd11, 4'hB, 4'hB, 1'b0, 4'h1, 4'h7, 1'b0, 1'b0, 8'd1);
        tbl[18] = mk(4'd11, 4'hB, 4'h5, 1'b0, 4'hC, 4'hE, 1'b0, 1'b0, 8'd1);
        tbl[19] = mk(4'd11, 4'hB, 4'h8, 1'b0, 4'h0, 4'hB, 1'b0, 1'b0, 8'd1);
        tbl[20] = mk(4'd11, 4'hB, 4'h6, 1'b0, 4'h6, 4'h1, 1'b0, 1'b0, 8'd1);
        tbl[21] = mk(4'd13, 4'h7, 4'h3, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 8'd1);
        tbl[22] = mk(4'd15, 4'hF, 4'hF, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 8'd1);
        tbl[23] = mk(4'd9,  4'h0, 4'hF, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 8'd5);
        tbl[24] = mk(4'd7,  4'h7, 4'h8, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 8'd1);

        // reset state
        repeat (2) @(negedge clk);
        check("reset cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_hi", 32'(rsp_hi), 32'd0);
        check("reset rsp_lo", 32'(rsp_lo), 32'd0);
        check("reset rsp_carry", 32'(rsp_carry), 32'd0);
        check("reset rsp_err", 32'(rsp_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post-reset cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < NT; i++) begin
            run(tbl[i], (i == 21) ? 3 : 0);
        end

        for (int i = 0; i < 24; i++) begin
            v = model(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            run(v, i % 3);
        end

        // reset in the middle of a MUL abandons it
        @(negedge clk);
        cmd_op = 4'd9;
        cmd_a = 4'hD;
        cmd_b = 4'hB;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        check("midrst cmd_ready", 32'(cmd_ready), 32'd0);
        check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst rsp_hi", 32'(rsp_hi), 32'd0);
        check("midrst rsp_lo", 32'(rsp_lo), 32'd0);
        check("midrst rsp_carry", 32'(rsp_carry), 32'd0);
        check("midrst rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("midrst ready_after", 32'(cmd_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("midrst no_response", 32'(seen), 32'd0);
        run(mk(4'd7, 4'h2, 4'h3, 1'b0, 4'h0, 4'h5, 1'b0, 1'b0, 8'd1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
